// File: rtl/seq_multiplier_pkg.sv
// Shared definitions for the sequential shift-add multiplier.
//   state_t        FSM state encoding (S_IDLE=0, S_RUN=1)
//   DEFAULT_WIDTH  default operand width used by seq_multiplier
// The signed-operand option is controlled by the MUL_SIGNED_EN macro. It is
// left undefined by default, which gives the unsigned-only build.
package seq_multiplier_pkg;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/mul_add_stage.sv
// Combinational WIDTH-bit adder that keeps the carry-out.
// It is kept separate so the ALU can reuse it.
//   x    in   WIDTH     first addend
//   y    in   WIDTH     second addend
//   sum  out  WIDTH+1   {carry, sum}
module mul_add_stage #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic [WIDTH:0]   sum
);

    assign sum = {1'b0, x} + {1'b0, y};

endmodule

// File: rtl/seq_multiplier.sv
// Multi-cycle shift-add multiplier. It forms one partial product per clock.
// The result is held until the next operation completes.
//   clk        in   1         rising-edge clock
//   rst        in   1         synchronous reset, active-high
//   start      in   1         request, accepted only in IDLE
//   a, b       in   WIDTH     operands, sampled on the accepting edge
//   signed_op  in   1         (MUL_SIGNED_EN only) treat a/b as two's complement
//   busy       out  1         high while an operation runs
//   done       out  1         one-cycle pulse when product/zero update
//   product    out  2*WIDTH   registered result
//   zero       out  1         registered (product == 0)
// Build option: define MUL_SIGNED_EN to add signed_op and the signed path.
//
// state  | meaning
// S_IDLE | waiting for start; product/zero held
// S_RUN  | one shift-add iteration per edge; cnt counts down to 1
module seq_multiplier
    import seq_multiplier_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
`ifdef MUL_SIGNED_EN
    input  logic               signed_op,
`endif
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product,
    output logic               zero
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(1);

    state_t             state;
    state_t             state_next;
    logic               load;
    logic               finish;

    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_step;
    logic [2*WIDTH-1:0] result;
    logic [WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]   addend;
    logic [WIDTH-1:0]   a_load;
    logic [WIDTH-1:0]   b_load;
    logic [WIDTH:0]     sum;
    logic [CNT_W-1:0]   cnt;

`ifdef MUL_SIGNED_EN
    logic neg;
    logic neg_load;

    // Magnitudes are held as unsigned WIDTH-bit values.
    // The most-negative operand therefore becomes 2^(WIDTH-1) without overflow.
    always_comb begin
        a_load   = a;
        b_load   = b;
        neg_load = 1'b0;
        if (signed_op) begin
            if (a[WIDTH-1]) a_load = -a;
            if (b[WIDTH-1]) b_load = -b;
            neg_load = a[WIDTH-1] ^ b[WIDTH-1];
        end
    end

    assign result = neg ? -acc_step : acc_step;
`else
    assign a_load = a;
    assign b_load = b;
    assign result = acc_step;
`endif

    // One iteration: add mcand into the upper half when the current multiplier
    // bit (acc[0]) is set. Then shift right. The carry becomes the new MSB.
    assign addend = acc[0] ? mcand : '0;

    mul_add_stage #(
        .WIDTH (WIDTH)
    ) u_add (
        .x   (acc[2*WIDTH-1:WIDTH]),
        .y   (addend),
        .sum (sum)
    );

    assign acc_step = {sum, acc[WIDTH-1:1]};
    assign busy     = (state == S_RUN);

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        load       = 1'b0;
        finish     = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    load       = 1'b1;
                    state_next = S_RUN;
                end
            end
            S_RUN: begin
                if (cnt == CNT_LAST) begin
                    finish     = 1'b1;
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc     <= '0;
            mcand   <= '0;
            cnt     <= '0;
            product <= '0;
            zero    <= 1'b1;
            done    <= 1'b0;
`ifdef MUL_SIGNED_EN
            neg     <= 1'b0;
`endif
        end else begin
            done <= finish;
            if (load) begin
                acc   <= {{WIDTH{1'b0}}, b_load};
                mcand <= a_load;
                cnt   <= CNT_LOAD;
`ifdef MUL_SIGNED_EN
                neg   <= neg_load;
`endif
            end else if (state == S_RUN) begin
                acc <= acc_step;
                cnt <= cnt - CNT_LAST;
            end
            if (finish) begin
                product <= result;
                zero    <= (result == '0);
            end
        end
    end

endmodule

// File: tb/tb_seq_multiplier.sv
module tb_seq_multiplier;
    localparam int W = 8;

    logic           clk;
    logic           rst;
    logic           start;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic           busy;
    logic           done;
    logic [2*W-1:0] product;
    logic           zero;
`ifdef MUL_SIGNED_EN
    logic           sop;
`endif

    seq_multiplier #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .a         (a),
        .b         (b),
`ifdef MUL_SIGNED_EN
        .signed_op (sop),
`endif
        .busy      (busy),
        .done      (done),
        .product   (product),
        .zero      (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2*W-1:0] prod;
        int             done_edge;
    } exp_t;

    exp_t           q[$];
    int             edge_n    = 0;
    int             free_edge = 0;
    int             rst_edge  = -10;
    logic [2*W-1:0] held      = '0;
    int             tests     = 0;
    int             errors    = 0;

    // Reference multiply, done with plain integer arithmetic.
    function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] x, input logic [W-1:0] y,
                                               input bit sg);
        longint px;
        longint py;
        if (sg) begin
            px = $signed(x);
            py = $signed(y);
        end else begin
            px = longint'(x);
            py = longint'(y);
        end
        return (2*W)'(px * py);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", nm, act, exp, edge_n);
        end
    endtask

    // Model: decides acceptance from its own idea of when the block is free.
    always @(posedge clk) begin
        bit sg;
        edge_n++;
`ifdef MUL_SIGNED_EN
        sg = sop;
`else
        sg = 1'b0;
`endif
        if (rst) begin
            rst_edge  = edge_n;
            free_edge = edge_n + 1;
        end else if (start && edge_n >= free_edge) begin
            q.push_back('{prod: ref_mul(a, b, sg), done_edge: edge_n + W});
            free_edge = edge_n + W + 1;
        end
    end

    // Monitor: compares the DUT outputs against the scoreboard between edges.
    always @(negedge clk) begin
        if (rst_edge == edge_n) begin
            q.delete();
            held = '0;
        end
        if (q.size() > 0 && q[0].done_edge == edge_n) begin
            chk("done_pulse", 32'(done), 32'd1);
            held = q[0].prod;
            void'(q.pop_front());
        end else begin
            chk("done_low", 32'(done), 32'd0);
        end
        chk("product", 32'(product), 32'(held));
        chk("zero", 32'(zero), 32'(held == '0));
        chk("busy", 32'(busy), 32'(edge_n <= free_edge - 2));
    end

    task automatic drive(input bit s, input logic [W-1:0] x, input logic [W-1:0] y, input bit sg);
        @(negedge clk);
        start = s;
        a     = x;
        b     = y;
`ifdef MUL_SIGNED_EN
        sop   = sg;
`else
        if (sg) $display("note: signed request in unsigned build treated as unsigned");
`endif
    endtask

    task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y, input bit sg);
        drive(1'b1, x, y, sg);
        drive(1'b0, W'($urandom), W'($urandom), 1'b0);
    endtask

    task automatic wait_drain();
        int n = 0;
        while (q.size() > 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (q.size() > 0) begin
            tests++;
            errors++;
            $display("FAIL drain_timeout: %0d results outstanding, expected 0", q.size());
            q.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        start = 1'b0;
        a     = '0;
        b     = '0;
        rst   = 1'b1;
`ifdef MUL_SIGNED_EN
        sop   = 1'b0;
`endif
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        issue(8'd56, 8'd42, 1'b0);
        wait_drain();
        issue(8'd255, 8'd255, 1'b0);
        wait_drain();
        issue(8'd0, 8'd77, 1'b0);
        wait_drain();

        // Start held high with operands changing every cycle. This covers the
        // ignore-while-busy case and the back-to-back reissue in the done cycle.
        for (int i = 0; i < 2 * W + 2; i++) drive(1'b1, W'($urandom), W'($urandom), 1'b0);
        drive(1'b0, '0, '0, 1'b0);
        wait_drain();

        // Reset asserted four cycles into an operation.
        issue(8'd200, 8'd100, 1'b0);
        repeat (2) drive(1'b0, '0, '0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        issue(8'd3, 8'd5, 1'b0);
        wait_drain();

`ifdef MUL_SIGNED_EN
        issue(8'hFD, 8'd5, 1'b1);
        wait_drain();
        issue(8'h80, 8'h80, 1'b1);
        wait_drain();
        issue(8'hFD, 8'd5, 1'b0);
        wait_drain();
        issue(8'h80, 8'h80, 1'b0);
        wait_drain();
`endif

        for (int i = 0; i < 40; i++) begin
            bit sg;
`ifdef MUL_SIGNED_EN
            sg = 1'($urandom);
`else
            sg = 1'b0;
`endif
            drive(1'($urandom), W'($urandom), W'($urandom), sg);
            repeat ($urandom_range(0, 3)) drive(1'b0, W'($urandom), W'($urandom), sg);
            if ($urandom_range(0, 7) == 0) begin
                drive(1'b1, W'($urandom_range(0, 3)), W'($urandom), sg);
                drive(1'b0, '0, '0, 1'b0);
                wait_drain();
            end
        end
        drive(1'b0, '0, '0, 1'b0);
        wait_drain();

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
